dpd_mem3: RTL and testbench
===========================

// Module: dpd_mem3
// PURPOSE
// - Complex memory-polynomial predistorter/PA model: memory depth 3 (taps m=0..2), nonlinear order 5 (|x|^k, k=0..4).
// - Computes y(n) = sum_{k,m} c[k*3+m] * x(n-m) * |x(n-m)|^k, with 15 complex coefficients.
// - Also exports the 15 basis terms (yy) for the adaptation engine; instanced in the dpd datapath and as the PA model.
// PARAMETERS
// - none; sizes fixed by package constants N_MEM=3, N_ORD=5, N_COEF=15.
// PORTS
// - clk        in   1        clock, all logic on rising edge
// - reset_b    in   1        asynchronous, active-low reset
// - sig_in_i   in   s20      input I, Q.19 signed (full scale +/-1.0)
// - sig_in_q   in   s20      input Q, Q.19 signed
// - sig_out_i  out  s20      output I, Q.19, scaled by 1/8
// - sig_out_q  out  s20      output Q, Q.19, scaled by 1/8
// - coeff      in   intf_coef_3_5  i[0:14], q[0:14] s20 Q.19 coefficients; index = k*3+m
// - yy         out  intf_coef_3_5  i[0:14], q[0:14] s20 Q.19 basis terms b[k*3+m]
// BEHAVIOUR
// - Reset: every pipeline/tap register clears to 0; sig_out_*, yy.* = 0 while reset_b=0 and until valid data flows.
// - Reset mid-operation: immediate clear, no partial state retained.
// - No handshake: one sample per clk, always enabled.
// - Magnitude: a=|i|, b=|q| (|-524288| -> 524287); mag = max + (min>>2) + (min>>3);
//   clamp to 524287 (u20, Q.19, <1.0).
// - Powers: p0=2^19 (treated as 1.0, i.e. basis k=0 is x itself), p1=mag, pk=(p(k-1)*mag)>>>19 for k=2..4 (floor).
// - Basis at tap 0: bk = (x*pk)>>>19 per component (floor), k=1..4; b0=x. All fit s20 since mag<1.
// - Taps m=1,2: basis vectors delayed 1 and 2 further cycles via register chain (shared across k).
// - Products: complex multiply c*b: re=ci*bi - cq*bq, im=ci*bq + cq*bi (40-bit each);
//   accumulate 15 terms in 48-bit signed.
// - Output: sig_out = sat_s20(acc >>> 22) (19 frac bits + 3 headroom bits); floor, saturate to [-524288, 524287].
// - coeff is sampled at the multiply stage each cycle; a coefficient change reaches sig_out after the remaining pipe stages.
// - Latency: exactly L=8 clk from sig_in to sig_out for tap m=0 (m-tap contributes at 8+m).
// - yy is registered so yy basis b[k*3+m] is time-aligned with the sig_out sample it produced.
// STRUCTURE
// - Shared package: typedefs s20/u20/s48/u32, constants N_MEM/N_ORD/N_COEF, sat_s20 function;
//   interface intf_coef_3_5 (s20 i[0:14], q[0:14]) in shared interface file.
// - Sub-module: cmult_acc (15-way complex MAC + shift/saturate); magnitude/power/basis pipe stays in dpd_mem3.
// TESTING
// - Reset: reset_b=0 with nonzero input -> sig_out=0, yy all 0; stays 0 for 8 clk after release with x=0.
// - Linear identity: c[0]=(524287,0), others 0, x=(262144,0) constant -> sig_out=(32767,0) after 8 clk.
// - Imag coef: c[0]=(0,524287), x=(262144,0) -> sig_out=(0,32767); yy.i[0]=262144.
// - Memory tap: c[2]=(524287,0), single-cycle impulse x=(262144,0) at n0 -> sig_out=(32767,0) only at n0+10.
// - Cubic term: c[6]=(524287,0), x=(262144,0) -> mag=262144, p2=131072, b6=65536, sig_out=(8191,0).
// - Saturation: all c=(-524288,0), x=(524287,0) -> sig_out_i=-524288 (clamped), sig_out_q=0.

Source files
------------

// File: rtl/dpd_mem3_pkg.sv
// dpd_mem3_pkg: shared types, sizes and fixed-point helpers for the memory-polynomial DPD
package dpd_mem3_pkg;
  localparam int N_MEM = 3;
  localparam int N_ORD = 5;
  localparam int N_COEF = N_MEM * N_ORD;
  typedef logic signed [19:0] s20;
  typedef logic [19:0] u20;
  typedef logic signed [47:0] s48;
  typedef logic [31:0] u32;
  localparam s20 S20_MAX = 20'h7FFFF;
  localparam s20 S20_MIN = 20'h80000;
  localparam u20 ONE_Q19 = 20'h80000;
  typedef struct packed {
    s20 xi;
    s20 xq;
    u20 p1;
    u20 p2;
    u20 p3;
    u20 p4;
  } stage_t;
  function automatic s20 sat_s20(input s48 v);
    return (v > 48'sd524287) ? S20_MAX : (v < -48'sd524288) ? S20_MIN : s20'(v);
  endfunction
  function automatic u20 abs_s20(input s20 v);
    return (v == S20_MIN) ? 20'h7FFFF : v[19] ? u20'(-v) : u20'(v);
  endfunction
  function automatic u20 mag_of(input s20 i, input s20 q);
    logic [20:0] a, b, mx, mn, s;
    a = {1'b0, abs_s20(i)};
    b = {1'b0, abs_s20(q)};
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    s = mx + (mn >> 2) + (mn >> 3);
    return (s > 21'd524287) ? 20'h7FFFF : s[19:0];
  endfunction
  function automatic u20 pmul(input u20 a, input u20 b);
    return u20'(({20'd0, a} * {20'd0, b}) >> 19);
  endfunction
  function automatic s20 bmul(input s20 x, input u20 p);
    return s20'((s48'(x) * s48'($signed({1'b0, p}))) >>> 19);
  endfunction
endpackage

// File: rtl/intf_coef_3_5.sv
// intf_coef_3_5: bundle of 15 complex Q.19 values indexed k*3+m
interface intf_coef_3_5;
  import dpd_mem3_pkg::*;
  s20 i [0:N_COEF-1];
  s20 q [0:N_COEF-1];
  modport mst (output i, q);
  modport slv (input i, q);
endinterface

// File: rtl/cmult_acc.sv
// cmult_acc: 15-way complex multiply-accumulate with Q.19 rescale and saturation
module cmult_acc
  import dpd_mem3_pkg::*;
(
  input  logic               clk,
  input  logic               reset_b,
  input  logic signed [19:0] b_i_i [0:N_COEF-1],
  input  logic signed [19:0] b_q_i [0:N_COEF-1],
  input  logic signed [19:0] c_i_i [0:N_COEF-1],
  input  logic signed [19:0] c_q_i [0:N_COEF-1],
  output logic signed [19:0] y_i_o,
  output logic signed [19:0] y_q_o
);
  s48 pr_d [0:N_COEF-1];
  s48 pi_d [0:N_COEF-1];
  s48 pr_q [0:N_COEF-1];
  s48 pi_q [0:N_COEF-1];
  s48 ar_d, ai_d, ar_q, ai_q;
  s20 y_i_d, y_q_d, y_i_q, y_q_q;
  // per-term complex products using the coefficients presented this cycle
  always_comb
    for (int j = 0; j < N_COEF; j++) begin
      pr_d[j] = s48'(c_i_i[j]) * s48'(b_i_i[j]) - s48'(c_q_i[j]) * s48'(b_q_i[j]);
      pi_d[j] = s48'(c_i_i[j]) * s48'(b_q_i[j]) + s48'(c_q_i[j]) * s48'(b_i_i[j]);
    end
  // sum all registered products
  always_comb begin
    ar_d = '0;
    ai_d = '0;
    for (int j = 0; j < N_COEF; j++) begin
      ar_d = ar_d + pr_q[j];
      ai_d = ai_d + pi_q[j];
    end
  end
  assign y_i_d = sat_s20(ar_q >>> 22);
  assign y_q_d = sat_s20(ai_q >>> 22);
  // product, accumulator and output registers
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      pr_q <= '{default: '0};
      pi_q <= '{default: '0};
      ar_q <= '0;
      ai_q <= '0;
      y_i_q <= '0;
      y_q_q <= '0;
    end else begin
      pr_q <= pr_d;
      pi_q <= pi_d;
      ar_q <= ar_d;
      ai_q <= ai_d;
      y_i_q <= y_i_d;
      y_q_q <= y_q_d;
    end
  assign y_i_o = y_i_q;
  assign y_q_o = y_q_q;
endmodule

// File: rtl/dpd_mem3.sv
// dpd_mem3: depth-3, order-5 complex memory-polynomial predistorter / PA model
module dpd_mem3
  import dpd_mem3_pkg::*;
(
  input  logic               clk,
  input  logic               reset_b,
  input  logic signed [19:0] sig_in_i,
  input  logic signed [19:0] sig_in_q,
  output logic signed [19:0] sig_out_i,
  output logic signed [19:0] sig_out_q,
  intf_coef_3_5.slv          coeff,
  intf_coef_3_5.mst          yy
);
  stage_t st_d [1:4];
  stage_t st_q [1:4];
  u20 pk [0:N_ORD-1];
  s20 bi_d [0:N_COEF-1];
  s20 bq_d [0:N_COEF-1];
  s20 bi_q [0:N_COEF-1];
  s20 bq_q [0:N_COEF-1];
  s20 yi_q [1:3][0:N_COEF-1];
  s20 yq_q [1:3][0:N_COEF-1];
  // magnitude first, then one new power per stage while x rides along
  always_comb begin
    st_d[1] = '0;
    st_d[1].xi = sig_in_i;
    st_d[1].xq = sig_in_q;
    st_d[1].p1 = mag_of(sig_in_i, sig_in_q);
    st_d[2] = st_q[1];
    st_d[2].p2 = pmul(st_q[1].p1, st_q[1].p1);
    st_d[3] = st_q[2];
    st_d[3].p3 = pmul(st_q[2].p2, st_q[2].p1);
    st_d[4] = st_q[3];
    st_d[4].p4 = pmul(st_q[3].p3, st_q[3].p1);
  end
  assign pk = '{ONE_Q19, st_q[4].p1, st_q[4].p2, st_q[4].p3, st_q[4].p4};
  // tap-0 basis from the finished powers; older taps shift down the chain
  always_comb
    for (int k = 0; k < N_ORD; k++) begin
      bi_d[k*N_MEM] = bmul(st_q[4].xi, pk[k]);
      bq_d[k*N_MEM] = bmul(st_q[4].xq, pk[k]);
      for (int m = 1; m < N_MEM; m++) begin
        bi_d[k*N_MEM+m] = bi_q[k*N_MEM+m-1];
        bq_d[k*N_MEM+m] = bq_q[k*N_MEM+m-1];
      end
    end
  // power pipe, basis taps and the basis delay that lines yy up with sig_out
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      st_q <= '{default: '0};
      bi_q <= '{default: '0};
      bq_q <= '{default: '0};
      yi_q <= '{default: '0};
      yq_q <= '{default: '0};
    end else begin
      st_q <= st_d;
      bi_q <= bi_d;
      bq_q <= bq_d;
      yi_q[1] <= bi_q;
      yq_q[1] <= bq_q;
      yi_q[2] <= yi_q[1];
      yq_q[2] <= yq_q[1];
      yi_q[3] <= yi_q[2];
      yq_q[3] <= yq_q[2];
    end
  assign yy.i = yi_q[3];
  assign yy.q = yq_q[3];
  cmult_acc u_mac (
    .clk     (clk),
    .reset_b (reset_b),
    .b_i_i   (bi_q),
    .b_q_i   (bq_q),
    .c_i_i   (coeff.i),
    .c_q_i   (coeff.q),
    .y_i_o   (sig_out_i),
    .y_q_o   (sig_out_q)
  );
endmodule

// File: tb/tb_dpd_mem3.sv
// tb_dpd_mem3: directed and randomized checks of dpd_mem3 against a behavioural model
module tb_dpd_mem3;
  import dpd_mem3_pkg::*;
  logic clk = 1'b0;
  logic reset_b;
  logic signed [19:0] sig_in_i, sig_in_q, sig_out_i, sig_out_q;
  intf_coef_3_5 cif ();
  intf_coef_3_5 yif ();
  dpd_mem3 dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .sig_in_i  (sig_in_i),
    .sig_in_q  (sig_in_q),
    .sig_out_i (sig_out_i),
    .sig_out_q (sig_out_q),
    .coeff     (cif),
    .yy        (yif)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 16;
  longint xr_i [16];
  longint xr_q [16];
  longint cr_i [16][15];
  longint cr_q [16][15];
  function automatic longint mabs(longint v);
    return (v < -524287) ? 524287 : (v < 0) ? -v : v;
  endfunction
  function automatic longint basis(longint xi, longint xq, int k, bit im);
    longint a = mabs(xi);
    longint b = mabs(xq);
    longint mg;
    longint p = 524288;
    mg = (a > b ? a : b) + ((a > b ? b : a) >> 2) + ((a > b ? b : a) >> 3);
    if (mg > 524287) mg = 524287;
    for (int j = 1; j <= k; j++) p = (j == 1) ? mg : (p * mg) >>> 19;
    return ((im ? xq : xi) * p) >>> 19;
  endfunction
  function automatic longint exp_yy(int j, bit im);
    int s = (cyc - 8 - j % N_MEM) % 16;
    return basis(xr_i[s], xr_q[s], j / N_MEM, im);
  endfunction
  function automatic longint exp_out(bit im);
    longint acc = 0;
    longint bi, bq, ci, cq;
    int s = (cyc - 3) % 16;
    for (int j = 0; j < N_COEF; j++) begin
      bi = exp_yy(j, 1'b0);
      bq = exp_yy(j, 1'b1);
      ci = cr_i[s][j];
      cq = cr_q[s][j];
      acc += im ? ci * bq + cq * bi : ci * bi - cq * bq;
    end
    acc = acc >>> 22;
    return acc > 524287 ? 524287 : acc < -524288 ? -524288 : acc;
  endfunction
  function automatic longint rnd_x();
    int r = $urandom_range(0, 7);
    return r == 0 ? -524288 : r == 1 ? 524287 : longint'($urandom_range(0, 1048575)) - 524288;
  endfunction
  task automatic tick(input longint xi, input longint xq);
    sig_in_i = 20'(xi);
    sig_in_q = 20'(xq);
    xr_i[cyc % 16] = reset_b ? xi : 0;
    xr_q[cyc % 16] = reset_b ? xq : 0;
    for (int j = 0; j < N_COEF; j++) begin
      cr_i[cyc % 16][j] = cif.i[j];
      cr_q[cyc % 16][j] = cif.q[j];
    end
    @(negedge clk);
    cyc++;
  endtask
  task automatic set_coef(input int j, input longint ci, input longint cq);
    cif.i[j] = 20'(ci);
    cif.q[j] = 20'(cq);
  endtask
  task automatic clear_and_flush();
    for (int j = 0; j < N_COEF; j++) set_coef(j, 0, 0);
    repeat (11) tick(0, 0);
  endtask
  task automatic test_reset();
    int bad = 0;
    reset_b = 1'b0;
    for (int j = 0; j < N_COEF; j++) set_coef(j, 100000, -50000);
    tick(300000, -200000);
    tick(-400000, 123456);
    checks++;
    if (sig_out_i !== 20'sd0 || sig_out_q !== 20'sd0) begin
      errors++;
      $display("FAIL reset_out got=(%0d,%0d) want=(0,0)", sig_out_i, sig_out_q);
    end
    for (int j = 0; j < N_COEF; j++) if (yif.i[j] !== 20'sd0 || yif.q[j] !== 20'sd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_yy nonzero_terms=%0d want=0", bad);
    end
    reset_b = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick(0, 0);
      checks++;
      if (sig_out_i !== 20'sd0 || sig_out_q !== 20'sd0) begin
        errors++;
        $display("FAIL post_reset t=%0d got=(%0d,%0d) want=(0,0)", t, sig_out_i, sig_out_q);
      end
    end
  endtask
  task automatic test_linear();
    longint e;
    clear_and_flush();
    set_coef(0, 524287, 0);
    for (int t = 0; t < 12; t++) begin
      tick(262144, 0);
      e = t >= 7 ? 32767 : 0;
      checks++;
      if (longint'(sig_out_i) !== e || sig_out_q !== 20'sd0) begin
        errors++;
        $display("FAIL linear t=%0d got=(%0d,%0d) want=(%0d,0)", t, sig_out_i, sig_out_q, e);
      end
    end
  endtask
  task automatic test_imag();
    longint e;
    clear_and_flush();
    set_coef(0, 0, 524287);
    for (int t = 0; t < 12; t++) begin
      tick(262144, 0);
      e = t >= 7 ? 32767 : 0;
      checks++;
      if (sig_out_i !== 20'sd0 || longint'(sig_out_q) !== e) begin
        errors++;
        $display("FAIL imag t=%0d got=(%0d,%0d) want=(0,%0d)", t, sig_out_i, sig_out_q, e);
      end
      e = t >= 7 ? 262144 : 0;
      checks++;
      if (longint'(yif.i[0]) !== e || yif.q[0] !== 20'sd0) begin
        errors++;
        $display("FAIL imag_yy0 t=%0d got=(%0d,%0d) want=(%0d,0)", t, yif.i[0], yif.q[0], e);
      end
    end
  endtask
  task automatic test_memtap();
    longint e;
    clear_and_flush();
    set_coef(2, 524287, 0);
    for (int t = 0; t < 14; t++) begin
      tick(t == 0 ? 262144 : 0, 0);
      e = t == 9 ? 32767 : 0;
      checks++;
      if (longint'(sig_out_i) !== e || sig_out_q !== 20'sd0) begin
        errors++;
        $display("FAIL memtap t=%0d got=(%0d,%0d) want=(%0d,0)", t, sig_out_i, sig_out_q, e);
      end
    end
  endtask
  task automatic test_cubic();
    longint e;
    clear_and_flush();
    set_coef(6, 524287, 0);
    for (int t = 0; t < 12; t++) begin
      tick(262144, 0);
      e = t >= 7 ? 8191 : 0;
      checks++;
      if (longint'(sig_out_i) !== e || sig_out_q !== 20'sd0) begin
        errors++;
        $display("FAIL cubic t=%0d got=(%0d,%0d) want=(%0d,0)", t, sig_out_i, sig_out_q, e);
      end
      e = t >= 7 ? 65536 : 0;
      checks++;
      if (longint'(yif.i[6]) !== e) begin
        errors++;
        $display("FAIL cubic_yy6 t=%0d got=%0d want=%0d", t, yif.i[6], e);
      end
    end
  endtask
  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      clear_and_flush();
      for (int j = 0; j < N_COEF; j++) set_coef(j, pass == 0 ? -524288 : 524287, 0);
      for (int t = 0; t < 12; t++) begin
        tick(524287, 0);
        checks++;
        if (longint'(sig_out_i) !== exp_out(1'b0) || sig_out_q !== 20'sd0) begin
          errors++;
          $display("FAIL sat_model p=%0d t=%0d got=(%0d,%0d) want=(%0d,0)", pass, t, sig_out_i, sig_out_q, exp_out(1'b0));
        end
        if (t >= 9) begin
          checks++;
          if (longint'(sig_out_i) !== (pass == 0 ? -524288 : 524287)) begin
            errors++;
            $display("FAIL sat_clamp p=%0d t=%0d got=%0d", pass, t, sig_out_i);
          end
        end
      end
    end
  endtask
  task automatic test_random();
    longint ei, eq;
    for (int t = 0; t < 300; t++) begin
      if (t % 37 == 0)
        for (int j = 0; j < N_COEF; j++)
          set_coef(j, longint'($urandom_range(0, 131072)) - 65536, longint'($urandom_range(0, 131072)) - 65536);
      tick(rnd_x(), rnd_x());
      ei = exp_out(1'b0);
      eq = exp_out(1'b1);
      checks++;
      if (longint'(sig_out_i) !== ei || longint'(sig_out_q) !== eq) begin
        errors++;
        $display("FAIL random_out t=%0d got=(%0d,%0d) want=(%0d,%0d)", t, sig_out_i, sig_out_q, ei, eq);
      end
      for (int j = 0; j < N_COEF; j++) begin
        checks++;
        if (longint'(yif.i[j]) !== exp_yy(j, 1'b0) || longint'(yif.q[j]) !== exp_yy(j, 1'b1)) begin
          errors++;
          $display("FAIL random_yy t=%0d j=%0d got=(%0d,%0d) want=(%0d,%0d)", t, j, yif.i[j], yif.q[j], exp_yy(j, 1'b0), exp_yy(j, 1'b1));
        end
      end
    end
  endtask
  task automatic test_reset_mid();
    int bad = 0;
    for (int t = 0; t < 20; t++) tick(rnd_x(), rnd_x());
    #2 reset_b = 1'b0;
    for (int s = 0; s < 16; s++) begin
      xr_i[s] = 0;
      xr_q[s] = 0;
    end
    #1;
    checks++;
    if (sig_out_i !== 20'sd0 || sig_out_q !== 20'sd0) begin
      errors++;
      $display("FAIL midreset_out got=(%0d,%0d) want=(0,0)", sig_out_i, sig_out_q);
    end
    for (int j = 0; j < N_COEF; j++) if (yif.i[j] !== 20'sd0 || yif.q[j] !== 20'sd0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_yy nonzero_terms=%0d want=0", bad);
    end
    tick(rnd_x(), rnd_x());
    tick(rnd_x(), rnd_x());
    reset_b = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick(rnd_x(), rnd_x());
      checks++;
      if (longint'(sig_out_i) !== exp_out(1'b0) || longint'(sig_out_q) !== exp_out(1'b1)) begin
        errors++;
        $display("FAIL midreset_resume t=%0d got=(%0d,%0d) want=(%0d,%0d)", t, sig_out_i, sig_out_q, exp_out(1'b0), exp_out(1'b1));
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_b = 1'b0;
    sig_in_i = '0;
    sig_in_q = '0;
    test_reset();
    test_linear();
    test_imag();
    test_memtap();
    test_cubic();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
